// File: rtl/boss_hit_rx.sv
// boss_hit_rx -- receiving end of the melee attack path.
//
// Builds the weapon hitbox from the weapon anchor, swing displacement and
// facing, tests it against the boss hitbox, and on a connecting swing applies
// damage, starts the invulnerability and hit-flash timers, and reports HP and
// death. Only one hit is allowed per swing (rising edge of attack_active).
//
// Ports:
//   clk, rst             system clock, asynchronous active-low reset
//   frame_tick           one-cycle pulse per video frame (timer base)
//   game_active          gameplay running; low reloads the boss
//   attack_active        swing animation in progress
//   pos_x/y_wpn_offset   weapon anchor
//   anim_x_offset        signed swing displacement
//   flip_hor_melee       1 = weapon faces left
//   boss_x, boss_y       boss hitbox top-left corner
//   boss_hp              current hit points
//   boss_hit             one-cycle pulse per registered hit
//   boss_flash           hit-flash request for the draw stage
//   boss_dead            HP exhausted
//   hit_count            saturating hits since reload
module boss_hit_rx #(
    parameter int unsigned BOSS_HP      = 100,
    parameter int unsigned DMG          = 10,
    parameter int unsigned IFRAME_TICKS = 30,
    parameter int unsigned FLASH_TICKS  = 8,
    parameter int unsigned BOSS_W       = 96,
    parameter int unsigned BOSS_H       = 128,
    parameter int unsigned WPN_LNG      = 48,
    parameter int unsigned WPN_HGT      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               game_active,
    input  logic               attack_active,
    input  logic [11:0]        pos_x_wpn_offset,
    input  logic [11:0]        pos_y_wpn_offset,
    input  logic signed [11:0] anim_x_offset,
    input  logic               flip_hor_melee,
    input  logic [11:0]        boss_x,
    input  logic [11:0]        boss_y,
    output logic [7:0]         boss_hp,
    output logic               boss_hit,
    output logic               boss_flash,
    output logic               boss_dead,
    output logic [7:0]         hit_count
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [7:0]        HP_INIT   = 8'(BOSS_HP);
    localparam logic [7:0]        DMG_V     = 8'(DMG);
    localparam logic [7:0]        IFRAME_V  = 8'(IFRAME_TICKS);
    localparam logic [7:0]        FLASH_V   = 8'(FLASH_TICKS);
    localparam logic signed [12:0] BOSS_W_S  = 13'(BOSS_W);
    localparam logic signed [12:0] BOSS_H_S  = 13'(BOSS_H);
    localparam logic signed [12:0] WPN_LNG_S = 13'(WPN_LNG);
    localparam logic signed [12:0] WPN_HGT_S = 13'(WPN_HGT);

    state_t      state_q, state_d;
    logic        overlap_q, overlap_d;
    logic        attack_prev_q, attack_prev_d;
    logic        armed_q, armed_d;
    logic [7:0]  boss_hp_q, boss_hp_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic        boss_hit_q, boss_hit_d;
    logic [7:0]  iframe_q, iframe_d;
    logic [7:0]  flash_q, flash_d;

    logic signed [12:0] anim_s, wl, wr, wt, wb, bl, br, bt, bb;
    logic        overlap;
    logic        hit;
    logic [7:0]  hp_after_hit;

    // Hitbox test. Everything is widened to 13-bit signed so a weapon that
    // swings past the left screen edge yields a negative wl rather than a
    // huge unsigned value.
    always_comb begin
        anim_s = {anim_x_offset[11], anim_x_offset};
        bl     = {1'b0, boss_x};
        bt     = {1'b0, boss_y};
        br     = bl + BOSS_W_S;
        bb     = bt + BOSS_H_S;
        if (flip_hor_melee) begin
            wl = {1'b0, pos_x_wpn_offset} - anim_s - WPN_LNG_S;
        end else begin
            wl = {1'b0, pos_x_wpn_offset} + anim_s;
        end
        wr = wl + WPN_LNG_S;
        wt = {1'b0, pos_y_wpn_offset};
        wb = wt + WPN_HGT_S;
        // Strict comparisons: touching edges do not count as contact.
        overlap = (wl < br) && (wr > bl) && (wt < bb) && (wb > bt);
    end

    // A hit needs a live boss, an armed swing still in progress and the
    // overlap seen one cycle earlier.
    always_comb begin
        hit          = game_active && (state_q == ALIVE) && armed_q
                       && overlap_q && attack_active;
        hp_after_hit = (boss_hp_q > DMG_V) ? (boss_hp_q - DMG_V) : 8'd0;
    end

    // State register.
    // NOTE: every flop is written with <= so all of them update from the
    // values that existed before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ALIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: the default at the top of each always_comb guarantees every path
    // assigns the output, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!game_active) begin
            state_d = ALIVE;
        end else begin
            case (state_q)
                ALIVE:   if (hit) state_d = (hp_after_hit == 8'd0) ? DEAD : INVULN;
                INVULN:  if (frame_tick && (iframe_q <= 8'd1)) state_d = ALIVE;
                DEAD:    state_d = DEAD;
                default: state_d = ALIVE;
            endcase
        end
    end

    // Datapath next values: arming, damage, counters and timers.
    always_comb begin
        overlap_d     = overlap;
        attack_prev_d = attack_active;
        boss_hp_d     = boss_hp_q;
        hit_count_d   = hit_count_q;
        boss_hit_d    = 1'b0;
        iframe_d      = iframe_q;
        flash_d       = flash_q;

        // Arm on a rising edge of attack_active; drop as soon as it falls.
        if (!attack_active) begin
            armed_d = 1'b0;
        end else if (!attack_prev_q) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        if (hit) begin
            boss_hp_d   = hp_after_hit;
            hit_count_d = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
            boss_hit_d  = 1'b1;
            armed_d     = 1'b0;
            // A frame_tick on this edge is deliberately swallowed: the
            // timers start from their full values.
            iframe_d    = IFRAME_V;
            flash_d     = FLASH_V;
        end else if ((state_q == INVULN) && frame_tick) begin
            iframe_d = (iframe_q != 8'd0) ? iframe_q - 8'd1 : 8'd0;
            flash_d  = (flash_q  != 8'd0) ? flash_q  - 8'd1 : 8'd0;
        end

        if (state_q == DEAD) begin
            boss_hp_d = 8'd0;
        end

        // Reload overrides everything, including a hit on the same edge.
        if (!game_active) begin
            boss_hp_d   = HP_INIT;
            hit_count_d = 8'd0;
            boss_hit_d  = 1'b0;
            armed_d     = 1'b0;
            iframe_d    = 8'd0;
            flash_d     = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overlap_q     <= 1'b0;
            attack_prev_q <= 1'b0;
            armed_q       <= 1'b0;
            boss_hp_q     <= HP_INIT;
            hit_count_q   <= 8'd0;
            boss_hit_q    <= 1'b0;
            iframe_q      <= 8'd0;
            flash_q       <= 8'd0;
        end else begin
            overlap_q     <= overlap_d;
            attack_prev_q <= attack_prev_d;
            armed_q       <= armed_d;
            boss_hp_q     <= boss_hp_d;
            hit_count_q   <= hit_count_d;
            boss_hit_q    <= boss_hit_d;
            iframe_q      <= iframe_d;
            flash_q       <= flash_d;
        end
    end

    // Outputs.
    always_comb begin
        boss_hp    = boss_hp_q;
        hit_count  = hit_count_q;
        boss_hit   = boss_hit_q;
        boss_flash = (state_q == INVULN) && (flash_q != 8'd0);
        boss_dead  = (state_q == DEAD);
    end

endmodule

// File: tb/tb_boss_hit_rx.sv
// Directed testbench for boss_hit_rx. A default-parameter instance covers the
// hitbox, arming, timer and reload behaviour; a second instance with
// BOSS_HP=15 covers HP saturation and death.
module tb_boss_hit_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, frame_tick, game_active, game_active_s;
    logic               attack_active, flip;
    logic [11:0]        pos_x, pos_y, boss_x, boss_y;
    logic signed [11:0] anim;

    logic [7:0] hp_m, cnt_m, hp_s, cnt_s;
    logic       hit_m, flash_m, dead_m, hit_s, flash_s, dead_s;

    int n_pass  = 0;
    int n_total = 0;
    int hits_m  = 0;
    int hits_s  = 0;
    int h0;

    boss_hit_rx dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .attack_active(attack_active), .pos_x_wpn_offset(pos_x),
        .pos_y_wpn_offset(pos_y), .anim_x_offset(anim), .flip_hor_melee(flip),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hp(hp_m), .boss_hit(hit_m),
        .boss_flash(flash_m), .boss_dead(dead_m), .hit_count(cnt_m)
    );

    boss_hit_rx #(.BOSS_HP(15), .DMG(10)) dut_small (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active_s),
        .attack_active(attack_active), .pos_x_wpn_offset(pos_x),
        .pos_y_wpn_offset(pos_y), .anim_x_offset(anim), .flip_hor_melee(flip),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hp(hp_s), .boss_hit(hit_s),
        .boss_flash(flash_s), .boss_dead(dead_s), .hit_count(cnt_s)
    );

    // boss_hit lasts one full cycle, so each pulse is seen at exactly one negedge.
    always @(negedge clk) begin
        if (hit_m === 1'b1) hits_m++;
        if (hit_s === 1'b1) hits_s++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic swing(input int n);
        attack_active = 1'b1;
        repeat (n) tick();
        attack_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic reload_m();
        game_active = 1'b0;
        tick();
        game_active = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; game_active = 1'b0; game_active_s = 1'b0;
        attack_active = 1'b0; flip = 1'b0; anim = 12'sd0;
        pos_x = 12'd380; pos_y = 12'd320; boss_x = 12'd400; boss_y = 12'd300;
        #12;
        check("rst_hp",       hp_m,    100);
        check("rst_hit",      hit_m,   0);
        check("rst_flash",    flash_m, 0);
        check("rst_dead",     dead_m,  0);
        check("rst_count",    cnt_m,   0);
        check("rst_hp_small", hp_s,    15);
        rst = 1'b1; game_active = 1'b1;
        tick(); tick();

        // First swing: wl=380..428 overlaps boss 400..496. Hit on 2nd edge.
        h0 = hits_m;
        attack_active = 1'b1;
        tick();
        check("hit_not_after_1_edge", hit_m, 0);
        tick();
        check("hit_after_2_edges", hit_m, 1);
        check("hp_after_hit1",     hp_m,  90);
        check("count_after_hit1",  cnt_m, 1);
        check("flash_after_hit1",  flash_m, 1);
        repeat (48) tick();
        attack_active = 1'b0;
        tick(); tick();
        check("one_hit_per_long_swing", hits_m - h0, 1);

        // Flash lasts 8 ticks; swing at tick 10 is ignored.
        repeat (7) ftick();
        check("flash_at_7_ticks", flash_m, 1);
        ftick();
        check("flash_at_8_ticks", flash_m, 0);
        ftick(); ftick();
        h0 = hits_m;
        swing(3);
        check("invuln_swing_pulses", hits_m - h0, 0);
        check("invuln_swing_hp",     hp_m, 90);

        // Swing raised during invulnerability stays armed and hits right
        // after the 30th tick returns the boss to ALIVE.
        repeat (19) ftick();
        attack_active = 1'b1;
        tick(); tick();
        check("armed_in_invuln_no_hit", hit_m, 0);
        ftick();
        check("tick30_edge_no_hit", hit_m, 0);
        tick();
        check("hit_after_iframes", hit_m, 1);
        check("hp_after_hit2",     hp_m,  80);
        check("count_after_hit2",  cnt_m, 2);
        attack_active = 1'b0;

        // Asynchronous reset mid-invulnerability, checked before any edge.
        rst = 1'b0;
        #2;
        check("async_rst_hp",    hp_m,    100);
        check("async_rst_count", cnt_m,   0);
        check("async_rst_hit",   hit_m,   0);
        check("async_rst_flash", flash_m, 0);
        check("async_rst_dead",  dead_m,  0);
        rst = 1'b1;
        tick();

        // Right edge exactly touching boss_x: wl=352, wr=400 -> no contact.
        pos_x = 12'd352;
        h0 = hits_m;
        swing(3);
        check("edge_touch_pulses", hits_m - h0, 0);
        check("edge_touch_hp",     hp_m, 100);
        pos_x = 12'd353;
        h0 = hits_m;
        swing(3);
        check("wl353_pulses", hits_m - h0, 1);
        check("wl353_hp",     hp_m, 90);
        reload_m();
        check("reload_hp",    hp_m,    100);
        check("reload_count", cnt_m,   0);
        check("reload_flash", flash_m, 0);

        // Facing left: wl = 520-20-48 = 452 -> hit; anim=-200 -> wl=672, miss.
        flip = 1'b1; pos_x = 12'd520; anim = 12'sd20;
        h0 = hits_m;
        swing(3);
        check("flip_hit_pulses", hits_m - h0, 1);
        check("flip_hit_hp",     hp_m, 90);
        reload_m();
        anim = -12'sd200;
        h0 = hits_m;
        swing(3);
        check("flip_miss_pulses", hits_m - h0, 0);
        check("flip_miss_hp",     hp_m, 100);

        // Negative wl: boss at x=0, wl=10-50=-40, wr=8 > 0 -> hit.
        flip = 1'b0; boss_x = 12'd0; pos_x = 12'd10; anim = -12'sd50;
        h0 = hits_m;
        swing(3);
        check("neg_wl_pulses", hits_m - h0, 1);
        check("neg_wl_hp",     hp_m, 90);
        reload_m();
        boss_x = 12'd400; pos_x = 12'd380; anim = 12'sd0;
        tick();

        // frame_tick on the hit edge is not applied: flash holds for 8 more ticks.
        attack_active = 1'b1;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("tick_on_hit_edge_hit", hit_m, 1);
        repeat (7) ftick();
        check("tick_on_hit_flash_7", flash_m, 1);
        ftick();
        check("tick_on_hit_flash_8", flash_m, 0);
        attack_active = 1'b0;
        tick();
        reload_m();
        tick();

        // game_active low on the would-be hit edge: reload wins.
        h0 = hits_m;
        attack_active = 1'b1;
        tick();
        game_active = 1'b0;
        tick();
        check("reload_vs_hit_hit", hit_m, 0);
        check("reload_vs_hit_hp",  hp_m,  100);
        game_active = 1'b1;
        attack_active = 1'b0;
        tick(); tick();
        check("reload_vs_hit_pulses", hits_m - h0, 0);

        // Small boss: 15 -> 5 -> 0 (saturated), dead, then reload.
        game_active_s = 1'b1;
        tick();
        h0 = hits_s;
        swing(3);
        check("small_hp_hit1",     hp_s, 5);
        check("small_pulses_hit1", hits_s - h0, 1);
        repeat (30) ftick();
        swing(3);
        check("small_hp_hit2",     hp_s, 0);
        check("small_dead",        dead_s, 1);
        check("small_dead_flash",  flash_s, 0);
        check("small_count",       cnt_s, 2);
        check("small_pulses_hit2", hits_s - h0, 2);
        swing(3);
        check("small_dead_no_pulse", hits_s - h0, 2);
        check("small_dead_hp_held",  hp_s, 0);
        game_active_s = 1'b0;
        tick();
        game_active_s = 1'b1;
        check("small_reload_hp",    hp_s,   15);
        check("small_reload_dead",  dead_s, 0);
        check("small_reload_count", cnt_s,  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/boss_hit_rx.md
Name: boss_hit_rx

Overview:
- Receiving end of the melee attack path: consumes the weapon hitbox position, animation offset and attack-active signal produced by the weapon logic.
- Decides whether a swing connects with the boss, applies damage, runs invulnerability and flash timers, and reports boss HP and death.
- Sits between the weapon subsystem and the boss draw/game-state logic, in the frame_tick domain of the main clock.

Parameters:
- BOSS_HP, 100: initial and reload hit points (max 255).
- DMG, 10: damage per connecting swing.
- IFRAME_TICKS, 30: frame_ticks of invulnerability after a hit.
- FLASH_TICKS, 8: frame_ticks boss_flash stays high after a hit (must be ≤ IFRAME_TICKS).
- BOSS_W, 96: boss hitbox width in px.
- BOSS_H, 128: boss hitbox height in px.
- WPN_LNG, 48: weapon hitbox length in px.
- WPN_HGT, 16: weapon hitbox height in px.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- frame_tick  in  1  one-cycle pulse per video frame
- game_active  in  1  gameplay running; low reloads the boss
- attack_active  in  1  swing animation in progress
- pos_x_wpn_offset  in  12  weapon anchor x
- pos_y_wpn_offset  in  12  weapon anchor y
- anim_x_offset  in  12 signed  swing displacement
- flip_hor_melee  in  1  1 = weapon faces left
- boss_x  in  12  boss hitbox left x
- boss_y  in  12  boss hitbox top y
- boss_hp  out  8  current hit points
- boss_hit  out  1  one-cycle pulse on each registered hit
- boss_flash  out  1  hit-flash request for the draw stage
- boss_dead  out  1  boss HP exhausted
- hit_count  out  8  saturating count of hits since reload

Behaviour:
- Reset (rst low, asynchronous): boss_hp=BOSS_HP, boss_hit=0, boss_flash=0, boss_dead=0, hit_count=0, state=ALIVE, armed=0, all timers 0.
- Hitbox, 13-bit signed arithmetic:
  - flip=0: wl = pos_x_wpn_offset + anim_x_offset.
  - flip=1: wl = pos_x_wpn_offset - anim_x_offset - WPN_LNG.
  - wr = wl + WPN_LNG; wt = pos_y_wpn_offset; wb = wt + WPN_HGT.
- Overlap is true iff wl < boss_x+BOSS_W, wr > boss_x, wt < boss_y+BOSS_H, and wb > boss_y. Edge-touching does not count.
- Overlap is registered into overlap_q (stage 1).
- Arming (one hit per swing):
  - armed is set on the rising edge of attack_active (previous sample 0, current 1).
  - armed is cleared on a hit or when attack_active is low.
- FSM states:
  - ALIVE: if armed and overlap_q and attack_active, then in the same edge:
    - boss_hp ← max(boss_hp − DMG, 0);
    - hit_count ← min(hit_count+1, 255);
    - boss_hit=1 for exactly one cycle;
    - armed←0; iframe_cnt←IFRAME_TICKS; flash_cnt←FLASH_TICKS.
    - Next state is DEAD if the new HP is 0, otherwise INVULN.
  - INVULN:
    - Hits are ignored, but arming still tracks attack_active.
    - Each frame_tick decrements iframe_cnt and flash_cnt (floor 0).
    - boss_flash = (flash_cnt != 0).
    - When iframe_cnt reaches 0 on a frame_tick, go to ALIVE. A swing still armed at that point can hit the following cycle.
  - DEAD: boss_dead=1, boss_flash=0, hits ignored, HP held at 0.
- Latency: inputs sampled at edge k produce boss_hit high and the updated boss_hp after edge k+1.
- game_active low: synchronous reload to the reset values, in any state (mid-INVULN and DEAD included). While low, no hits occur.
- Simultaneous events:
  - frame_tick on the hit edge: the counters load their full values; the tick is not applied that cycle.
  - game_active low on the hit edge: reload wins and boss_hit stays 0.
- DMG ≥ remaining HP: HP saturates to 0 (no wrap) and the FSM enters DEAD.
- Negative wl (weapon off the left screen edge) is compared signed; no wrap to a large unsigned value.

Test Plan:
- Reset then game_active=1; boss at (400,300), weapon at (380,320), anim 0, flip 0, pulse attack_active → boss_hit once, 2 edges after the input; boss_hp 100→90; hit_count=1; boss_flash=1.
- Hold attack_active high across the entire overlap for 50 cycles → exactly one boss_hit.
- Second swing 10 frame_ticks after a hit → ignored, HP stays 90. Swing after 30 ticks → HP=80. boss_flash drops after 8 ticks.
- Weapon right edge exactly at boss_x (wl=352, flip 0) → no hit. Move wl to 353 → hit.
- flip=1, pos_x_wpn_offset=520, anim_x_offset=20 → wl=452, overlap → hit. Set anim_x_offset to −200 → wl=672, no hit.
- BOSS_HP=15, DMG=10: two hits → HP 5 then 0, boss_dead=1; further swings give no pulse. game_active low for 1 cycle → HP=15, dead=0, hit_count=0. Assert rst mid-INVULN → all outputs return to reset values immediately, without waiting for a clock edge.
